// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and widths for the reg16 write arbiter
package reg_arb_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  typedef logic [3:0] burst_cnt_t;

endpackage

// File: rtl/reg16_arbiter_if.sv
// rtl/reg16_arbiter_if.sv - requester-side bus of the reg16 write arbiter
interface reg16_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*WORD_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic [WORD_W-1:0]       q;

  modport master (
    output req, lock, wdata,
    input  ack, grant_id, busy, q
  );

  modport slave (
    input  req, lock, wdata,
    output ack, grant_id, busy, q
  );

endinterface

// File: rtl/reg16.sv
// rtl/reg16.sv - plain 16-bit load-enable register with no reset of its own
module reg16
  import reg_arb_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] q_d;
  logic [WORD_W-1:0] q_q;

  always_comb begin
    q_d = load ? din : q_q;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reg16_arbiter_rr_pick.sv
// rtl/reg16_arbiter_rr_pick.sv - combinational round-robin picker, ptr has top priority
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/reg16_arbiter.sv
// rtl/reg16_arbiter.sv - round-robin write arbiter with locked bursts for one 16-bit register
module reg16_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg16_arbiter_if.slave  bus
);

  localparam int         ID_W    = $clog2(N_REQ);
  localparam burst_cnt_t MAX_CNT = burst_cnt_t'(MAX_BURST);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  burst_cnt_t        cnt_q, cnt_d;
  burst_cnt_t        cnt_inc;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  ack_c;
  logic [ID_W-1:0]   gid_c;
  logic              load_c;
  logic [WORD_W-1:0] din_c;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cnt_inc = cnt_q + burst_cnt_t'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_c   = '0;
    gid_c   = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            ack_c[pick_idx] = 1'b1;
            gid_c           = pick_idx;
            ptr_d           = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
            if (bus.lock[pick_idx] && (MAX_BURST > 1)) begin
              state_d = OWNED;
              owner_d = pick_idx;
              cnt_d   = burst_cnt_t'(1);
            end
          end
        end
        OWNED: begin
          // Owner dropping req abandons the lock without a write.
          if (bus.req[owner_q]) begin
            ack_c[owner_q] = 1'b1;
            gid_c          = owner_q;
            cnt_d          = cnt_inc;
            if (!bus.lock[owner_q] || (cnt_inc == MAX_CNT)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The register has no reset, so reset is applied as a forced load of zero.
  always_comb begin
    din_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack_c[i]) begin
        din_c = bus.wdata[i*WORD_W +: WORD_W];
      end
    end
    if (rst) begin
      din_c = '0;
    end
    load_c = rst | (|ack_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  reg16 u_reg (
    .clk  (clk),
    .load (load_c),
    .din  (din_c),
    .q    (bus.q)
  );

  assign bus.ack      = ack_c;
  assign bus.grant_id = gid_c;
  assign bus.busy     = (state_q == OWNED) && !rst;

endmodule
